maltsev_basic_op: RTL and testbench
===================================

Name: maltsev_basic_op

Overview:
- Parametrised successor to the fixed 16-bit, 2-input zero operation. One start/ready-handshaked unit implements three basic recursive-function primitives:
  - zero (o)
  - successor (s)
  - projection (I)
- Width and arity are parameters. Operand selection is a sequential scan, so latency is uniform and no wide mux is needed.
- Sits beside the composition and recursion controllers, which drive ST and wait on RD.

Parameters:
- BW, 16, operand and result width in bits.
- INC, 2, number of input operands (arity), at least 1.
- SELW, 4, width of the SEL index; 2^SELW must be at least INC.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, synchronous, active-high.
- ST  input  1  start; a rising edge (ST=1 while previous sample 0) requests an operation.
- OP  input  2  operation: 0 = zero, 1 = successor of IN[SEL], 2 = projection IN[SEL], 3 = reserved.
- SEL  input  SELW  operand index for successor/projection; ignored for zero.
- IN  input  BW*INC  flattened operands; operand i is IN[i*BW +: BW].
- RD  output  1  ready; 1 = idle with result valid, 0 = busy.
- RES  output  BW  result.
- OVF  output  1  successor wrapped (operand was all ones).
- ERR  output  1  reserved OP, or SEL >= INC.

Behaviour:
- Start detection
  - Register STold samples ST on every posedge, including during RST. ST held high across reset release never triggers.
  - Start condition: ST=1 and STold=0, sampled while state is IDLE.
- Reset: RD=1, RES=0, OVF=0, ERR=0, state IDLE, scan index 0. Reset mid-operation aborts immediately with the same values.
- States
  - IDLE: RD=1; outputs hold the last result.
  - SCAN: RD=0.
- IDLE -> SCAN on the start posedge (cycle k):
  - latch OP, SEL and all IN operands into internal registers;
  - RD=0, OVF=0, ERR=0, idx=0, accumulator=0.
  - Input changes after cycle k do not affect the result.
- SCAN, posedges k+1 .. k+INC:
  - each posedge examines latched operand idx;
  - if idx==SEL_latched, accumulator <= operand;
  - then idx increments.
- Completion (posedge k+INC+1): compute outputs, set RD=1, return to IDLE. RD is low for exactly INC+1 cycles.
  - OP=0: RES=0, OVF=0, ERR=0.
  - OP=1: RES = accumulator+1 mod 2^BW; OVF=1 iff accumulator == all ones; ERR=0.
  - OP=2: RES=accumulator, OVF=0, ERR=0.
  - OP=3: RES=0, OVF=0, ERR=1.
  - OP=1 or 2 with SEL_latched >= INC: RES=0, OVF=0, ERR=1. No operand matches during the scan.
- All operations take the same latency, including zero and error cases.
- Edges while busy
  - A rising ST edge while in SCAN, including the completion posedge, is ignored and not queued.
  - STold keeps tracking, so ST must fall and rise again after RD=1.
- Back-to-back: the earliest accepted restart is the posedge after RD returns to 1.
- RES, OVF and ERR change only at completion or reset; they hold stable while RD=1.
- Arithmetic is unsigned; the successor carry-out feeds only OVF.

Test Plan (BW=16, INC=2 unless noted):
- Reset with ST high, then release RST with ST still high -> RD=1, RES=0, no start. Drop ST, then raise it with OP=0 -> RD low for 3 cycles, then RES=0x0000, RD=1.
- OP=1, SEL=1, IN1=0x1234, IN0=0xFFFF -> after 3 busy cycles RES=0x1235, OVF=0. Change IN1 mid-scan -> RES still 0x1235.
- OP=1, SEL=0, IN0=0xFFFF -> RES=0x0000, OVF=1, ERR=0.
- OP=2, SEL=3 -> ERR=1, RES=0. Then OP=3 -> ERR=1, RES=0, and latency is still 3 cycles in both cases.
- Pulse ST again during SCAN -> ignored, single completion. Assert RST mid-scan -> next posedge RD=1, RES=0, OVF=0, ERR=0.
- INC=4, BW=8: OP=2, SEL=3, IN3=0xA5 -> RD low for 5 cycles, RES=0xA5.

Source files
------------

// File: rtl/maltsev_basic_op.sv
// Zero / successor / projection primitive over INC operands of BW bits, start/ready handshake.
// Latency: RD low for exactly INC+1 cycles after an accepted ST rising edge, for every OP.
// Backpressure: ST edges while busy are dropped, not queued; caller must wait for RD=1 and re-raise ST.
module maltsev_basic_op #(
  parameter int BW   = 16,
  parameter int INC  = 2,
  parameter int SELW = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ST,
  input  logic [1:0]        OP,
  input  logic [SELW-1:0]   SEL,
  input  logic [BW*INC-1:0] IN,
  output logic              RD,
  output logic [BW-1:0]     RES,
  output logic              OVF,
  output logic              ERR
);

  // Scan index must reach INC, which marks the completion cycle.
  localparam int IW = $clog2(INC + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q;
  logic              st_old_q;
  logic [1:0]        op_q;
  logic [SELW-1:0]   sel_q;
  logic [BW-1:0]     opnd_q [INC];
  logic [IW-1:0]     idx_q;
  logic [BW-1:0]     acc_q;
  logic              rd_q;
  logic [BW-1:0]     res_q;
  logic              ovf_q;
  logic              err_q;

  logic              start;
  logic              sel_oob;
  logic              sel_hit;
  logic              scan_last;
  logic [BW:0]       succ;
  logic [BW-1:0]     res_d;
  logic              ovf_d;
  logic              err_d;

  assign start     = ST && !st_old_q && (state_q == IDLE);
  assign sel_oob   = 32'(sel_q) >= 32'(INC);
  assign sel_hit   = 32'(idx_q) == 32'(sel_q);
  assign scan_last = 32'(idx_q) == 32'(INC);
  // Carry-out of the increment is the wrap flag and goes nowhere else.
  assign succ      = {1'b0, acc_q} + (BW+1)'(1);

  // Result that will be published at the completion edge.
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    err_d = 1'b0;
    case (op_q)
      2'd0: begin
      end
      2'd1: begin
        if (sel_oob) begin
          err_d = 1'b1;
        end else begin
          res_d = succ[BW-1:0];
          ovf_d = succ[BW];
        end
      end
      2'd2: begin
        if (sel_oob) err_d = 1'b1;
        else         res_d = acc_q;
      end
      default: err_d = 1'b1;
    endcase
  end

  // Handshake FSM: latch operands on start, shift-scan them one per cycle, publish on completion.
  always_ff @(posedge CLK) begin
    // ST history tracks through reset so a level held across reset release is not an edge.
    st_old_q <= ST;
    if (RST) begin
      state_q <= IDLE;
      op_q    <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      rd_q    <= 1'b1;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < INC; i++) opnd_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= OP;
            sel_q <= SEL;
            for (int i = 0; i < INC; i++) opnd_q[i] <= IN[i*BW +: BW];
            idx_q   <= '0;
            acc_q   <= '0;
            rd_q    <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (scan_last) begin
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            rd_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            // Head of the shift chain is always operand idx, so no wide mux is needed.
            if (sel_hit) acc_q <= opnd_q[0];
            for (int i = 0; i < INC - 1; i++) opnd_q[i] <= opnd_q[i+1];
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RD  = rd_q;
  assign RES = res_q;
  assign OVF = ovf_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_maltsev_basic_op.sv
// Bench for maltsev_basic_op: one instance at BW=16/INC=2, one at BW=8/INC=4.
// Hand-written vector table plus random operations against an arithmetic reference model.
module tb_maltsev_basic_op;

  logic        CLK = 1'b0;
  logic        RST;
  always #5 CLK = ~CLK;

  // Instance A: BW=16, INC=2
  logic        st_a;
  logic [1:0]  op_a;
  logic [3:0]  sel_a;
  logic [31:0] in_a;
  logic        rd_a;
  logic [15:0] res_a;
  logic        ovf_a;
  logic        err_a;

  // Instance B: BW=8, INC=4
  logic        st_b;
  logic [1:0]  op_b;
  logic [3:0]  sel_b;
  logic [31:0] in_b;
  logic        rd_b;
  logic [7:0]  res_b;
  logic        ovf_b;
  logic        err_b;

  maltsev_basic_op #(.BW(16), .INC(2), .SELW(4)) dut_a (
    .CLK(CLK), .RST(RST), .ST(st_a), .OP(op_a), .SEL(sel_a), .IN(in_a),
    .RD(rd_a), .RES(res_a), .OVF(ovf_a), .ERR(err_a)
  );

  maltsev_basic_op #(.BW(8), .INC(4), .SELW(4)) dut_b (
    .CLK(CLK), .RST(RST), .ST(st_b), .OP(op_b), .SEL(sel_b), .IN(in_b),
    .RD(rd_b), .RES(res_b), .OVF(ovf_b), .ERR(err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: returns {err, ovf, res[15:0]}; the operand is picked by shifting, the carry of +1 is ovf.
  function automatic logic [17:0] ref16(input logic [1:0] op, input logic [3:0] sel, input logic [31:0] in);
    logic [16:0] v;
    if (op == 2'd0) return 18'd0;
    if (op == 2'd3 || sel >= 4'd2) return {1'b1, 17'd0};
    v = 17'((in >> (32'(sel) * 16)) & 32'h0000_FFFF);
    if (op == 2'd1) v = v + 17'd1;
    return {1'b0, v};
  endfunction

  // Reference: returns {err, ovf, res[7:0]}.
  function automatic logic [9:0] ref8(input logic [1:0] op, input logic [3:0] sel, input logic [31:0] in);
    logic [8:0] v;
    if (op == 2'd0) return 10'd0;
    if (op == 2'd3 || sel >= 4'd4) return {1'b1, 9'd0};
    v = 9'((in >> (32'(sel) * 8)) & 32'h0000_00FF);
    if (op == 2'd1) v = v + 9'd1;
    return {1'b0, v};
  endfunction

  // mode 0: plain; 1: ST re-pulsed mid-scan; 2: ST rises right at the completion edge.
  task automatic run_a(input logic [1:0] op, input logic [3:0] sel, input logic [31:0] in,
                       input logic [17:0] exp, input int mode, input string name);
    int busy;
    bit done;
    logic [15:0] held;
    @(negedge CLK); st_a = 1'b0;
    @(negedge CLK);
    op_a = op; sel_a = sel; in_a = in; st_a = 1'b1;
    busy = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge CLK);
      if (rd_a) begin
        done = 1'b1;
      end else begin
        busy++;
        if (busy == 1) begin
          st_a = 1'b0; in_a = ~in; op_a = ~op; sel_a = ~sel;
        end
        if (mode == 1 && busy == 2) st_a = 1'b1;
        if (mode == 2 && busy == 3) st_a = 1'b1;
      end
    end
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " latency"}, busy, 3);
    chk({name, " res"}, 32'(res_a), 32'(exp[15:0]));
    chk({name, " ovf"}, 32'(ovf_a), 32'(exp[16]));
    chk({name, " err"}, 32'(err_a), 32'(exp[17]));
    held = res_a;
    repeat (3) @(negedge CLK);
    chk({name, " no restart"}, 32'(rd_a), 32'd1);
    chk({name, " res held"}, 32'(res_a), 32'(held));
  endtask

  task automatic run_b(input logic [1:0] op, input logic [3:0] sel, input logic [31:0] in,
                       input logic [9:0] exp, input string name);
    int busy;
    bit done;
    @(negedge CLK); st_b = 1'b0;
    @(negedge CLK);
    op_b = op; sel_b = sel; in_b = in; st_b = 1'b1;
    busy = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge CLK);
      if (rd_b) done = 1'b1;
      else begin
        busy++;
        if (busy == 1) begin
          st_b = 1'b0; in_b = ~in;
        end
      end
    end
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " latency"}, busy, 5);
    chk({name, " res"}, 32'(res_b), 32'(exp[7:0]));
    chk({name, " ovf"}, 32'(ovf_b), 32'(exp[8]));
    chk({name, " err"}, 32'(err_b), 32'(exp[9]));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  sel;
    logic [31:0] in;
    logic [15:0] res;
    logic        ovf;
    logic        err;
    int          mode;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rop;
    logic [3:0]  rsel;
    logic [31:0] rin;

    tbl[0] = '{2'd0, 4'd0, 32'h1234_FFFF, 16'h0000, 1'b0, 1'b0, 0};
    tbl[1] = '{2'd1, 4'd1, 32'h1234_FFFF, 16'h1235, 1'b0, 1'b0, 0};
    tbl[2] = '{2'd1, 4'd0, 32'h1234_FFFF, 16'h0000, 1'b1, 1'b0, 0};
    tbl[3] = '{2'd2, 4'd3, 32'h1234_FFFF, 16'h0000, 1'b0, 1'b1, 0};
    tbl[4] = '{2'd3, 4'd0, 32'h1234_FFFF, 16'h0000, 1'b0, 1'b1, 0};
    tbl[5] = '{2'd2, 4'd0, 32'h0001_BEEF, 16'hBEEF, 1'b0, 1'b0, 1};
    tbl[6] = '{2'd2, 4'd1, 32'h0001_BEEF, 16'h0001, 1'b0, 1'b0, 2};
    tbl[7] = '{2'd1, 4'd2, 32'h0000_0000, 16'h0000, 1'b0, 1'b1, 0};
    tbl[8] = '{2'd1, 4'd1, 32'hFFFE_0000, 16'hFFFF, 1'b0, 1'b0, 0};
    tbl[9] = '{2'd0, 4'd1, 32'hFFFF_FFFF, 16'h0000, 1'b0, 1'b0, 1};

    // Reset with ST held high through release: no start may result.
    RST = 1'b1;
    st_a = 1'b1; op_a = 2'd0; sel_a = 4'd0; in_a = 32'd0;
    st_b = 1'b1; op_b = 2'd0; sel_b = 4'd0; in_b = 32'd0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset rd", 32'(rd_a), 32'd1);
    chk("reset res", 32'(res_a), 32'd0);
    chk("reset ovf", 32'(ovf_a), 32'd0);
    chk("reset err", 32'(err_a), 32'd0);
    chk("reset rd_b", 32'(rd_b), 32'd1);
    repeat (3) @(negedge CLK);
    chk("st held no start", 32'(rd_a), 32'd1);

    for (int i = 0; i < 10; i++)
      run_a(tbl[i].op, tbl[i].sel, tbl[i].in, {tbl[i].err, tbl[i].ovf, tbl[i].res},
            tbl[i].mode, $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rsel = 4'($urandom_range(0, 3));
      rin  = $urandom;
      if ($urandom_range(0, 3) == 0) rin[15:0] = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) rin[31:16] = 16'hFFFF;
      run_a(rop, rsel, rin, ref16(rop, rsel, rin), 0, $sformatf("rand_a%0d", i));
    end

    run_b(2'd2, 4'd3, 32'hA500_0000, 10'h0A5, "b_proj3");
    for (int i = 0; i < 20; i++) begin
      rop  = 2'($urandom_range(0, 3));
      rsel = 4'($urandom_range(0, 5));
      rin  = $urandom;
      if ($urandom_range(0, 2) == 0) rin[8*rsel[1:0] +: 8] = 8'hFF;
      run_b(rop, rsel, rin, ref8(rop, rsel, rin), $sformatf("rand_b%0d", i));
    end

    // Reset in the middle of a scan aborts with cleared outputs and no late completion.
    run_a(2'd1, 4'd1, 32'h1234_FFFF, 18'h01235, 0, "pre_abort");
    @(negedge CLK); st_a = 1'b0;
    @(negedge CLK);
    op_a = 2'd1; sel_a = 4'd0; in_a = 32'h0000_FFFF; st_a = 1'b1;
    @(negedge CLK);
    chk("abort busy", 32'(rd_a), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort rd", 32'(rd_a), 32'd1);
    chk("abort res", 32'(res_a), 32'd0);
    chk("abort ovf", 32'(ovf_a), 32'd0);
    chk("abort err", 32'(err_a), 32'd0);
    RST = 1'b0; st_a = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort stays idle", 32'(rd_a), 32'd1);
    chk("abort res stays", 32'(res_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
